mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory responder that services the load/store requests issued by the instruction decode/control stage.
- Each request carries read_mem, write_mem and the size code apply_mask (0 = word, 1 = half, 2 = byte).
- The block accepts one request at a time, runs a ready/ack handshake to a 32-bit word-addressed data memory, builds byte-lane enables, replicates store data and extracts/extends load data.
- It returns one response per accepted request; the pipeline holds the requesting instruction while req_ready is low.

Parameters:
- TIMEOUT, default 15: number of BUS cycles without mem_ack before the access is aborted with a timeout error; valid range 1..255.

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- read_mem  input  1  load request
- write_mem  input  1  store request
- apply_mask  input  2  access size: 0 word, 1 half, 2 byte, 3 reserved
- unsigned_load  input  1  zero-extend sub-word loads (LBU/LHU); 0 = sign-extend
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- rdata  output  32  load result, aligned and extended; 0 for stores and errors
- err  output  2  0 ok, 1 misaligned, 2 timeout, 3 illegal request
- mem_en  output  1  memory access strobe, held until ack
- mem_we  output  4  byte-lane write enables; lane i = bits 8i+7:8i (little-endian)
- mem_addr  output  30  word address = addr[31:2]
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read word, valid with mem_ack
- mem_ack  input  1  access complete

Behaviour:
- Reset (nrst=0 at a clock edge):
  - State goes to IDLE. Timeout counter clears.
  - Outputs: req_ready=1, resp_valid=0, rdata=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access drops mem_en on the next edge and produces no response; a late mem_ack is ignored.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1. A request is accepted on an edge where req_valid=1.
  - Request fields are registered at acceptance; later changes to the inputs are ignored.
  - Error checks at acceptance, in priority order:
    - illegal (err=3): read_mem==write_mem, or apply_mask==3.
    - misaligned (err=1): half with addr[0]=1, or word with addr[1:0]!=0.
  - On an error, go to RESP with no memory access. Otherwise go to BUS.
- BUS:
  - mem_en=1; mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - mem_we:
    - word 4'b1111.
    - half: 4'b0011 if addr[1]=0, else 4'b1100.
    - byte: 4'b0001 << addr[1:0].
    - all zero for loads.
  - mem_wdata: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
  - mem_ack=1: capture the result and go to RESP. mem_ack may arrive in the first BUS cycle.
  - Timeout: the counter increments each BUS cycle without ack. When it reaches TIMEOUT, go to RESP with err=2 and drop mem_en. mem_ack in the same cycle as the timeout wins (err=0).
- Load extraction:
  - byte = mem_rdata lane addr[1:0]; half = lane pair addr[1].
  - Sign-extend unless unsigned_load=1; word loads are passed through unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle, with rdata/err valid; req_ready=0; then go to IDLE.
- Latency:
  - Accept at edge N; BUS during cycle N+1; ack in cycle N+k gives resp_valid in cycle N+k+1. Minimum is 2 cycles to response.
  - Error requests: resp_valid in cycle N+1.
- mem_ack outside BUS is ignored.
- Back-to-back operation: the next request can be accepted on the edge after the RESP cycle.

Test Plan:
- Word load: addr=0x100, apply_mask=0, mem_rdata=0xDEADBEEF, ack in first BUS cycle -> mem_addr=0x40, mem_we=0, resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- Byte store: addr=0x103, wdata=0x000000A5 -> mem_we=4'b1000, mem_wdata=0xA5A5A5A5; ack after 3 BUS cycles -> mem_en held 3 cycles, then one resp_valid pulse with err=0.
- Sub-word loads from mem_rdata=0x80FF7F01:
  - LB addr=2 -> rdata=0xFFFFFFFF.
  - LBU addr=3 -> rdata=0x00000080.
  - LH addr=0 -> rdata=0x00007F01.
  - LH addr=2 -> rdata=0xFFFF80FF.
- Errors:
  - Half load at addr=0x101 -> no mem_en; resp_valid next cycle with err=1.
  - read_mem=write_mem=1 -> err=3.
  - apply_mask=3 -> err=3.
- Timeout with TIMEOUT=15 and no ack -> mem_en high 15 cycles, resp err=2, rdata=0. Repeat with ack in the 15th cycle -> err=0.
- nrst=0 during BUS -> mem_en=0 and req_ready=1 after the edge, no resp_valid; a subsequent word store completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory responder for the load/store path.
// Accepts one request at a time, runs it against a word-addressed memory with
// a ready/ack handshake, and returns exactly one response per request.
//
// Handshake semantics:
//   request side : a request transfers on a rising edge where req_valid=1 and
//                  req_ready=1; req_ready is high only while idle, and all
//                  request fields are captured on that edge.
//   memory side  : mem_en rises with mem_addr/mem_we/mem_wdata stable and keeps
//                  them stable until an edge with mem_ack=1 (or the timeout);
//                  mem_ack while mem_en=0 carries no meaning and is ignored.
//   response side: resp_valid is a single-cycle pulse with rdata/err valid;
//                  there is no back-pressure on the response.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic [1:0]  apply_mask,
  input  logic        unsigned_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // FSM state and per-request context
  state_t      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        load_q, load_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  // Request classification; illegal beats misaligned
  function automatic logic [1:0] classify(input logic rd, input logic wr,
                                          input logic [1:0] size,
                                          input logic [1:0] low);
    logic [1:0] r;
    r = ERR_OK;
    if ((rd == wr) || (size == 2'd3)) begin
      r = ERR_ILLEGAL;
    end else if ((size == SZ_HALF) && low[0]) begin
      r = ERR_MISALIGN;
    end else if ((size == SZ_WORD) && (low != 2'b00)) begin
      r = ERR_MISALIGN;
    end
    return r;
  endfunction

  // Byte-lane enables for a store (little-endian lanes)
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] low);
    logic [3:0] r;
    case (size)
      SZ_WORD: r = 4'b1111;
      SZ_HALF: r = low[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: r = 4'b0001 << low;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate right-aligned store data into every lane it may land in
  function automatic logic [31:0] replicate(input logic [1:0] size,
                                            input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_HALF: r = {2{d[15:0]}};
      SZ_BYTE: r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed lane(s) from the memory word and extend to 32 bits
  function automatic logic [31:0] extract(input logic [1:0] size,
                                          input logic uns,
                                          input logic [1:0] low,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (low)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = low[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Next-state, request capture, timeout counting and response formation
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    load_d      = load_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = 32'd0;
    err_d       = ERR_OK;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d      = read_mem;
          size_d      = apply_mask;
          uns_d       = unsigned_load;
          lane_d      = addr[1:0];
          mem_addr_d  = addr[31:2];
          mem_we_d    = write_mem ? lane_enables(apply_mask, addr[1:0]) : 4'b0000;
          mem_wdata_d = replicate(apply_mask, wdata);
          tmo_cnt_d   = 8'd0;
          err_d       = classify(read_mem, write_mem, apply_mask, addr[1:0]);
          // Faulty requests respond straight away without touching memory
          state_d     = (err_d == ERR_OK) ? BUS : RESP;
        end
      end

      BUS: begin
        if (mem_ack) begin
          // An ack in the cycle the counter expires still completes normally
          rdata_d = load_q ? extract(size_q, uns_q, lane_q, mem_rdata) : 32'd0;
          state_d = RESP;
        end else if ((tmo_cnt_q + 8'd1) == TIMEOUT_CNT) begin
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and context registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= 8'd0;
      load_q      <= 1'b0;
      size_q      <= SZ_WORD;
      uns_q       <= 1'b0;
      lane_q      <= 2'd0;
      mem_addr_q  <= 30'd0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      load_q      <= load_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_en     = (state_q == BUS);
  // Lane enables are only meaningful while the strobe is up
  assign mem_we     = mem_en ? mem_we_q : 4'b0000;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a behavioural
// model of the expected response, lane enables and bus occupancy.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        read_mem = 1'b0;
  logic        write_mem = 1'b0;
  logic [1:0]  apply_mask = 2'd0;
  logic        unsigned_load = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        req_ready, resp_valid, mem_en;
  logic [31:0] rdata, mem_wdata;
  logic [1:0]  err;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .read_mem(read_mem), .write_mem(write_mem), .apply_mask(apply_mask),
    .unsigned_load(unsigned_load), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .err(err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [33:0] exp_q[$];        // {err, rdata}
  logic [33:0] exp_e;
  logic        bus_exp = 1'b0;
  logic        exp_store = 1'b0;
  logic [29:0] exp_addr = 30'd0;
  logic [3:0]  exp_we = 4'd0;
  logic [31:0] exp_wd = 32'd0;
  logic        started = 1'b0;
  int          ack_delay = 0;
  int          bus_cnt = 0;
  int          en_cnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rword = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] m_err(input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic [31:0] a);
    if (rd == wr || sz == 2'd3) return 2'd3;
    if (sz == 2'd1 && (a % 2) != 0) return 2'd1;
    if (sz == 2'd0 && (a % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_we(input logic wr, input logic [1:0] sz,
                                      input logic [31:0] a);
    logic [3:0] r;
    if (!wr) return 4'd0;
    if (sz == 2'd0) r = 4'hF;
    else if (sz == 2'd1) r = 4'b0011 << (a % 4);
    else r = 4'b0001 << (a % 4);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    if (sz == 2'd2) return {24'd0, wd[7:0]} * 32'h0101_0101;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> ((a % 4) * 8);
    if (sz == 2'd2) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // per-cycle compare process plus memory responder
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got resp_valid=1, expected 0");
      end else begin
        exp_e = exp_q.pop_front();
        check("resp_err", {30'd0, err}, {30'd0, exp_e[33:32]});
        check("resp_rdata", rdata, exp_e[31:0]);
      end
    end
    if (mem_en) begin
      en_cnt++;
      if (!bus_exp) begin
        tests++; fails++;
        $display("FAIL unexpected_mem_en: got mem_en=1, expected 0");
      end else begin
        check("mem_addr", {2'd0, mem_addr}, {2'd0, exp_addr});
        check("mem_we", {28'd0, mem_we}, {28'd0, exp_we});
        if (exp_store) check("mem_wdata", mem_wdata, exp_wd);
      end
    end
    if (started && nrst)
      check("req_ready", {31'd0, req_ready}, {31'd0, !(mem_en || resp_valid)});
    if (mem_en) begin
      bus_cnt++;
      mem_ack = force_ack || (ack_delay != 0 && bus_cnt == ack_delay);
    end else begin
      bus_cnt = 0;
      mem_ack = force_ack;
    end
    mem_rdata = mem_ack ? rword : $urandom();
  end

  // driver: one request, waits for its response, checks latency and literals
  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int dly,
                        input logic [1:0] lit_err, input logic [31:0] lit_rdata);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int          e_bus, k;
    e_err = m_err(rd, wr, sz, a);
    e_bus = 0;
    e_rd  = 32'd0;
    if (e_err == 2'd0) begin
      if (dly == 0 || dly > TIMEOUT) begin
        e_bus = TIMEOUT;
        e_err = 2'd2;
      end else begin
        e_bus = dly;
        if (rd) e_rd = m_load(sz, uns, a, rw);
      end
    end
    @(negedge clk);
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    exp_addr  = a[31:2];
    exp_we    = m_we(wr, sz, a);
    exp_wd    = m_wdata(sz, wd);
    exp_store = wr;
    bus_exp   = (e_bus != 0);
    ack_delay = dly;
    rword     = rw;
    en_cnt    = 0;
    exp_q.push_back({e_err, e_rd});
    read_mem = rd; write_mem = wr; apply_mask = sz; unsigned_load = uns;
    addr = a; wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    read_mem = $urandom_range(0, 1); write_mem = $urandom_range(0, 1);
    apply_mask = 2'($urandom_range(0, 3)); unsigned_load = $urandom_range(0, 1);
    addr = $urandom(); wdata = $urandom();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 100);
    check({name, "_latency"}, k, e_bus + 1);
    check({name, "_en_cycles"}, en_cnt, e_bus);
    if (resp_valid) begin
      check({name, "_lit_err"}, {30'd0, err}, {30'd0, lit_err});
      check({name, "_lit_rdata"}, rdata, lit_rdata);
    end else begin
      exp_q.delete();
    end
    bus_exp = 1'b0;
  endtask

  initial begin
    // model pinned to hand-computed values
    check("model_lb",  m_load(2'd2, 1'b0, 32'd2, 32'h80FF_7F01), 32'hFFFF_FFFF);
    check("model_lbu", m_load(2'd2, 1'b1, 32'd3, 32'h80FF_7F01), 32'h0000_0080);
    check("model_lh0", m_load(2'd1, 1'b0, 32'd0, 32'h80FF_7F01), 32'h0000_7F01);
    check("model_lh2", m_load(2'd1, 1'b0, 32'd2, 32'h80FF_7F01), 32'hFFFF_80FF);
    check("model_sb_we", {28'd0, m_we(1'b1, 2'd2, 32'h103)}, 32'h0000_0008);
    check("model_sb_wd", m_wdata(2'd2, 32'h0000_00A5), 32'hA5A5_A5A5);

    // reset state
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata",      rdata, 32'd0);
    check("rst_err",        {30'd0, err}, 32'd0);
    check("rst_mem_en",     {31'd0, mem_en}, 32'd0);
    check("rst_mem_we",     {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr",   {2'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    started = 1'b1;

    //      name     rd    wr    sz    uns   addr          wdata         mem word      dly err   rdata
    do_req("lw",    1'b1, 1'b0, 2'd0, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 1,  2'd0, 32'hDEADBEEF);
    do_req("sb",    1'b0, 1'b1, 2'd2, 1'b0, 32'h103,      32'h0000_00A5, 32'h0,       3,  2'd0, 32'h0);
    do_req("lb2",   1'b1, 1'b0, 2'd2, 1'b0, 32'h2,        32'h0,        32'h80FF_7F01, 1, 2'd0, 32'hFFFF_FFFF);
    do_req("lbu3",  1'b1, 1'b0, 2'd2, 1'b1, 32'h3,        32'h0,        32'h80FF_7F01, 2, 2'd0, 32'h0000_0080);
    do_req("lh0",   1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        32'h0,        32'h80FF_7F01, 1, 2'd0, 32'h0000_7F01);
    do_req("lh2",   1'b1, 1'b0, 2'd1, 1'b0, 32'h2,        32'h0,        32'h80FF_7F01, 4, 2'd0, 32'hFFFF_80FF);
    do_req("lhu2",  1'b1, 1'b0, 2'd1, 1'b1, 32'h2,        32'h0,        32'h80FF_7F01, 1, 2'd0, 32'h0000_80FF);
    do_req("lb1",   1'b1, 1'b0, 2'd2, 1'b0, 32'h41,       32'h0,        32'h80FF_7F01, 1, 2'd0, 32'h0000_007F);
    do_req("sh2",   1'b0, 1'b1, 2'd1, 1'b0, 32'h102,      32'h1234_BEEF, 32'h0,       2,  2'd0, 32'h0);
    do_req("sw",    1'b0, 1'b1, 2'd0, 1'b0, 32'h10,       32'h1234_5678, 32'h0,       2,  2'd0, 32'h0);
    do_req("lh_mis",1'b1, 1'b0, 2'd1, 1'b0, 32'h101,      32'h0,        32'h0,        1,  2'd1, 32'h0);
    do_req("lw_mis",1'b1, 1'b0, 2'd0, 1'b0, 32'h102,      32'h0,        32'h0,        1,  2'd1, 32'h0);
    do_req("rdwr",  1'b1, 1'b1, 2'd0, 1'b0, 32'h100,      32'h0,        32'h0,        1,  2'd3, 32'h0);
    do_req("nop",   1'b0, 1'b0, 2'd0, 1'b0, 32'h100,      32'h0,        32'h0,        1,  2'd3, 32'h0);
    do_req("mask3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h100,      32'h0,        32'h0,        1,  2'd3, 32'h0);
    do_req("prio",  1'b1, 1'b1, 2'd1, 1'b0, 32'h101,      32'h0,        32'h0,        1,  2'd3, 32'h0);
    do_req("tmo",   1'b1, 1'b0, 2'd0, 1'b0, 32'h200,      32'h0,        32'h1111_2222, 0, 2'd2, 32'h0);
    do_req("ack15", 1'b1, 1'b0, 2'd0, 1'b0, 32'h200,      32'h0,        32'hCAFE_F00D, 15, 2'd0, 32'hCAFE_F00D);
    do_req("ack16", 1'b0, 1'b1, 2'd2, 1'b0, 32'h201,      32'h0000_0033, 32'h0,       16, 2'd2, 32'h0);

    // reset in the middle of a bus access
    @(negedge clk);
    exp_addr = 30'h80; exp_we = 4'd0; exp_store = 1'b0; bus_exp = 1'b1; ack_delay = 0;
    read_mem = 1'b1; write_mem = 1'b0; apply_mask = 2'd0; addr = 32'h200; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_bus_active", {31'd0, mem_en}, 32'd1);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    bus_exp = 1'b0;
    // stray acks while idle must not start anything
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    check("stray_ack_idle", {31'd0, req_ready}, 32'd1);
    do_req("sw_post", 1'b0, 1'b1, 2'd0, 1'b0, 32'h300, 32'hA1B2_C3D4, 32'h0, 2, 2'd0, 32'h0);
    do_req("lw_post", 1'b1, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 32'hA1B2_C3D4, 1, 2'd0, 32'hA1B2_C3D4);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
